// File: rtl/ahb_wait_state_bridge.sv
// Single-outstanding AHB-Lite bridge that inserts fixed or LFSR-driven wait states before forwarding each transfer.
// Upstream HREADY is low from acceptance until one cycle after the downstream data phase; every output is a flop.
module ahb_wait_state_bridge #(
  parameter int unsigned WAIT_CYCLES = 0,
  parameter bit          RANDOM_WAIT = 1'b0,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic        clock,
  input  logic        reset,
  output logic        io_in_hready,
  input  logic [1:0]  io_in_htrans,
  input  logic [2:0]  io_in_hsize,
  input  logic        io_in_hwrite,
  input  logic [30:0] io_in_haddr,
  input  logic [31:0] io_in_hwdata,
  output logic        io_in_hresp,
  output logic [31:0] io_in_hrdata,
  input  logic        io_out_hready,
  output logic [1:0]  io_out_htrans,
  output logic [2:0]  io_out_hsize,
  output logic        io_out_hwrite,
  output logic [30:0] io_out_haddr,
  output logic [31:0] io_out_hwdata,
  input  logic        io_out_hresp,
  input  logic [31:0] io_out_hrdata
);

  typedef enum logic [2:0] {IDLE, WAIT, ADDR, DATA, ERR, RESP} state_t;

  state_t      state;
  logic [15:0] lfsr;
  logic [3:0]  wcnt;
  logic        cap_wdata;
  logic [31:0] rdata_q;
  logic        resp_q;
  logic        lfsr_fb;
  logic [3:0]  wait_load;
  logic        accept;
  logic        unused_htrans0;

  assign lfsr_fb        = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  assign wait_load      = RANDOM_WAIT ? lfsr[3:0] : 4'(WAIT_CYCLES);
  // NONSEQ and SEQ both carry a real transfer; BUSY/IDLE are dropped.
  assign accept         = io_in_htrans[1];
  assign unused_htrans0 = io_in_htrans[0];

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      lfsr          <= LFSR_SEED;
      wcnt          <= 4'd0;
      cap_wdata     <= 1'b0;
      rdata_q       <= '0;
      resp_q        <= 1'b0;
      io_in_hready  <= 1'b1;
      io_in_hresp   <= 1'b0;
      io_in_hrdata  <= '0;
      io_out_htrans <= 2'b00;
      io_out_hsize  <= '0;
      io_out_hwrite <= 1'b0;
      io_out_haddr  <= '0;
      io_out_hwdata <= '0;
    end else begin
      // Write data arrives in the cycle after the address phase and is then held for the downstream data phase.
      cap_wdata <= 1'b0;
      if (cap_wdata) io_out_hwdata <= io_in_hwdata;

      case (state)
        IDLE, RESP: begin
          if (accept) begin
            io_out_hsize  <= io_in_hsize;
            io_out_hwrite <= io_in_hwrite;
            io_out_haddr  <= io_in_haddr;
            lfsr          <= {lfsr[14:0], lfsr_fb};
            wcnt          <= wait_load;
            cap_wdata     <= 1'b1;
            io_in_hready  <= 1'b0;
            io_in_hresp   <= 1'b0;
            io_in_hrdata  <= '0;
            if (wait_load != 4'd0) begin
              state <= WAIT;
            end else begin
              state         <= ADDR;
              io_out_htrans <= 2'b10;
            end
          end else begin
            state        <= IDLE;
            io_in_hready <= 1'b1;
            io_in_hresp  <= 1'b0;
            io_in_hrdata <= '0;
          end
        end

        WAIT: begin
          wcnt <= wcnt - 4'd1;
          if (wcnt <= 4'd1) begin
            state         <= ADDR;
            io_out_htrans <= 2'b10;
          end
        end

        ADDR: begin
          if (io_out_hready) begin
            state         <= DATA;
            io_out_htrans <= 2'b00;
          end
        end

        DATA: begin
          // Only the completing cycle's HRESP counts; a stalled ERROR first cycle is ignored.
          if (io_out_hready) begin
            rdata_q <= io_out_hwrite ? 32'h0 : io_out_hrdata;
            resp_q  <= io_out_hresp;
            if (io_out_hresp) begin
              state       <= ERR;
              io_in_hresp <= 1'b1;
            end else begin
              state        <= RESP;
              io_in_hready <= 1'b1;
              io_in_hresp  <= 1'b0;
              io_in_hrdata <= io_out_hwrite ? 32'h0 : io_out_hrdata;
            end
          end
        end

        ERR: begin
          state        <= RESP;
          io_in_hready <= 1'b1;
          io_in_hresp  <= resp_q;
          io_in_hrdata <= rdata_q;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_wait_state_bridge.sv
// Directed and LFSR-randomised checks of ahb_wait_state_bridge against a bench RAM slave and a scoreboard.
module tb_ahb_wait_state_bridge;
  localparam int NI = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        in_hready  [NI];
  logic [1:0]  in_htrans  [NI];
  logic [2:0]  in_hsize   [NI];
  logic        in_hwrite  [NI];
  logic [30:0] in_haddr   [NI];
  logic [31:0] in_hwdata  [NI];
  logic        in_hresp   [NI];
  logic [31:0] in_hrdata  [NI];
  logic [1:0]  out_htrans [NI];
  logic [2:0]  out_hsize  [NI];
  logic        out_hwrite [NI];
  logic [30:0] out_haddr  [NI];
  logic [31:0] out_hwdata [NI];

  int         stall_cfg [NI];
  logic [1:0] err_cfg   [NI];   // bit0: ERROR on completion, bit1: HRESP high during stall cycles

  int vectors = 0;
  int miscompares = 0;

  // Instance 0: no waits, 1: 5 waits, 2: LFSR waits, 3: 10 waits.
  for (genvar g = 0; g < NI; g++) begin : gi
    logic        s_rdy;
    logic        s_rsp;
    logic [31:0] s_rd;
    bit [31:0]   mem [bit [30:0]];
    bit          dph;
    bit          dwr;
    logic [30:0] dad;
    int          cnt;

    ahb_wait_state_bridge #(
      .WAIT_CYCLES((g == 1) ? 5 : ((g == 3) ? 10 : 0)),
      .RANDOM_WAIT(g == 2),
      .LFSR_SEED(16'hACE1)
    ) dut (
      .clock(clk), .reset(reset),
      .io_in_hready(in_hready[g]), .io_in_htrans(in_htrans[g]), .io_in_hsize(in_hsize[g]),
      .io_in_hwrite(in_hwrite[g]), .io_in_haddr(in_haddr[g]), .io_in_hwdata(in_hwdata[g]),
      .io_in_hresp(in_hresp[g]), .io_in_hrdata(in_hrdata[g]),
      .io_out_hready(s_rdy), .io_out_htrans(out_htrans[g]), .io_out_hsize(out_hsize[g]),
      .io_out_hwrite(out_hwrite[g]), .io_out_haddr(out_haddr[g]), .io_out_hwdata(out_hwdata[g]),
      .io_out_hresp(s_rsp), .io_out_hrdata(s_rd)
    );

    always @(posedge clk) begin
      if (reset) begin
        dph = 1'b0;
        cnt = 0;
        s_rdy <= 1'b1;
        s_rsp <= 1'b0;
        s_rd  <= 32'h0;
      end else begin
        if (dph && s_rdy) begin
          if (dwr && !s_rsp) mem[dad] = out_hwdata[g];
          dph = 1'b0;
        end
        if (s_rdy && out_htrans[g][1]) begin
          dph = 1'b1;
          dwr = out_hwrite[g];
          dad = out_haddr[g];
          cnt = stall_cfg[g];
        end
        if (dph && cnt > 0) begin
          cnt--;
          s_rdy <= 1'b0;
          s_rsp <= err_cfg[g][1] | err_cfg[g][0];
          s_rd  <= 32'h0;
        end else if (dph) begin
          s_rdy <= 1'b1;
          s_rsp <= err_cfg[g][0];
          s_rd  <= (dwr || err_cfg[g][0]) ? 32'h0 : (mem.exists(dad) ? mem[dad] : 32'h0);
        end else begin
          s_rdy <= 1'b1;
          s_rsp <= 1'b0;
          s_rd  <= 32'h0;
        end
      end
    end
  end

  typedef struct {
    logic [31:0] rd;
    logic        rsp;
    int          stall;
  } exp_t;
  exp_t sb [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Entered #1 after an edge with the bridge ready; returns #1 into the cycle whose HREADY completes the transfer.
  task automatic xfer(input int i, input bit wr, input logic [30:0] a, input logic [31:0] wd,
                      output logic [31:0] rd, output logic rsp, output int stall, output int ns_at,
                      output logic err1);
    in_htrans[i] = 2'b10;
    in_hwrite[i] = wr;
    in_haddr[i]  = a;
    in_hsize[i]  = 3'd2;
    @(posedge clk); #1;
    in_htrans[i] = 2'b00;
    in_hwdata[i] = wd;
    stall = 0;
    ns_at = -1;
    err1  = 1'b0;
    for (int k = 1; k <= 64 && in_hready[i] !== 1'b1; k++) begin
      stall++;
      err1 = in_hresp[i];
      if (ns_at < 0 && out_htrans[i] == 2'b10) ns_at = k;
      @(posedge clk); #1;
    end
    chk("hready_timeout", {31'h0, in_hready[i]}, 32'h1);
    rd  = in_hrdata[i];
    rsp = in_hresp[i];
  endtask

  task automatic run(input string tag, input int i, input bit wr, input logic [30:0] a,
                     input logic [31:0] wd, input logic [31:0] erd, input logic ersp, input int estall,
                     output int ns, output logic e1);
    exp_t        e;
    logic [31:0] rd;
    logic        rsp;
    int          st;
    sb.push_back('{rd: erd, rsp: ersp, stall: estall});
    xfer(i, wr, a, wd, rd, rsp, st, ns, e1);
    e = sb.pop_front();
    chk({tag, "_rdata"}, rd, e.rd);
    chk({tag, "_resp"}, {31'h0, rsp}, {31'h0, e.rsp});
    chk({tag, "_stall"}, 32'(st), 32'(e.stall));
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  initial begin
    int          ns;
    logic        e1;
    logic [15:0] lm;
    bit [31:0]   mdl [16];
    bit          wr;
    int          ai;
    logic [31:0] wd;
    int          d;
    int          nw;
    int          gap;

    for (int i = 0; i < NI; i++) begin
      in_htrans[i] = 2'b00; in_hsize[i] = 3'd0; in_hwrite[i] = 1'b0;
      in_haddr[i]  = '0;    in_hwdata[i] = '0;
      stall_cfg[i] = 0;     err_cfg[i] = 2'b00;
    end
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) begin
      chk("rst_in_hready", {31'h0, in_hready[i]}, 32'h1);
      chk("rst_out_htrans", {30'h0, out_htrans[i]}, 32'h0);
    end
    chk("rst_in_hresp", {31'h0, in_hresp[0]}, 32'h0);
    chk("rst_in_hrdata", in_hrdata[0], 32'h0);
    chk("rst_out_haddr", {1'b0, out_haddr[0]}, 32'h0);
    chk("rst_out_hwdata", out_hwdata[0], 32'h0);
    chk("rst_out_ctrl", {28'h0, out_hsize[0], out_hwrite[0]}, 32'h0);
    reset = 1'b0;

    // Zero wait states: two stall cycles per transfer
    run("w0_wr", 0, 1'b1, 31'h100, 32'hDEADBEEF, 32'h0, 1'b0, 2, ns, e1);
    chk("w0_wr_nonseq", 32'(ns), 32'd1);
    @(posedge clk); #1;
    run("w0_rd", 0, 1'b0, 31'h100, 32'h0, 32'hDEADBEEF, 1'b0, 2, ns, e1);

    // Five wait states: NONSEQ at T+6, seven stall cycles
    run("w5_wr", 1, 1'b1, 31'h40, 32'h1234_5678, 32'h0, 1'b0, 7, ns, e1);
    @(posedge clk); #1;
    run("w5_rd", 1, 1'b0, 31'h40, 32'h0, 32'h1234_5678, 1'b0, 7, ns, e1);
    chk("w5_nonseq", 32'(ns), 32'd6);

    // Back-to-back: each next transfer presented in the RESP cycle
    run("b2b_wr1", 0, 1'b1, 31'h104, 32'hA5A5_0001, 32'h0, 1'b0, 2, ns, e1);
    run("b2b_wr2", 0, 1'b1, 31'h108, 32'h5A5A_0002, 32'h0, 1'b0, 2, ns, e1);
    run("b2b_rd1", 0, 1'b0, 31'h104, 32'h0, 32'hA5A5_0001, 1'b0, 2, ns, e1);
    run("b2b_rd2", 0, 1'b0, 31'h108, 32'h0, 32'h5A5A_0002, 1'b0, 2, ns, e1);

    // Downstream data-phase stalls hold the bridge
    stall_cfg[0] = 3;
    run("dst_wr", 0, 1'b1, 31'h10C, 32'h0BAD_CAFE, 32'h0, 1'b0, 5, ns, e1);
    run("dst_rd", 0, 1'b0, 31'h10C, 32'h0, 32'h0BAD_CAFE, 1'b0, 5, ns, e1);

    // Two-cycle downstream ERROR, then an OKAY transfer
    stall_cfg[0] = 1; err_cfg[0] = 2'b11;
    run("err_rd", 0, 1'b0, 31'h100, 32'h0, 32'h0, 1'b1, 4, ns, e1);
    chk("err_first_cycle", {31'h0, e1}, 32'h1);
    stall_cfg[0] = 0; err_cfg[0] = 2'b00;
    @(posedge clk); #1;
    run("post_err_rd", 0, 1'b0, 31'h100, 32'h0, 32'hDEADBEEF, 1'b0, 2, ns, e1);

    // HRESP high while downstream HREADY is low must not count
    stall_cfg[0] = 2; err_cfg[0] = 2'b10;
    run("glitch_rd", 0, 1'b0, 31'h104, 32'h0, 32'hA5A5_0001, 1'b0, 4, ns, e1);
    stall_cfg[0] = 0; err_cfg[0] = 2'b00;
    @(posedge clk); #1;

    // LFSR-driven waits with random traffic, gaps of IDLE/BUSY, and downstream stalls
    lm = 16'hACE1;
    for (int k = 0; k < 16; k++) mdl[k] = 32'h0;
    for (int n = 0; n < 1000; n++) begin
      wr = 1'($urandom_range(0, 1));
      ai = $urandom_range(0, 15);
      wd = $urandom;
      d  = $urandom_range(0, 2);
      stall_cfg[2] = d;
      nw = int'(lm[3:0]);
      lm = lfsr_next(lm);
      run("rnd", 2, wr, 31'h200 + 31'(ai * 4), wd, wr ? 32'h0 : mdl[ai], 1'b0, nw + 2 + d, ns, e1);
      if (wr) mdl[ai] = wd;
      gap = $urandom_range(0, 2);
      repeat (gap) begin
        in_htrans[2] = 2'($urandom_range(0, 1));
        @(posedge clk); #1;
      end
      in_htrans[2] = 2'b00;
    end
    stall_cfg[2] = 0;
    for (int k = 0; k < 16; k++) begin
      nw = int'(lm[3:0]);
      lm = lfsr_next(lm);
      run("rnd_mem", 2, 1'b0, 31'h200 + 31'(k * 4), 32'h0, mdl[k], 1'b0, nw + 2, ns, e1);
    end

    // Reset during a 10-cycle WAIT abandons the transfer
    @(posedge clk); #1;
    run("w10_wr", 3, 1'b1, 31'h80, 32'hCAFE_F00D, 32'h0, 1'b0, 12, ns, e1);
    @(posedge clk); #1;
    in_htrans[3] = 2'b10; in_hwrite[3] = 1'b0; in_haddr[3] = 31'h80;
    @(posedge clk); #1;
    in_htrans[3] = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pre_hready", {31'h0, in_hready[3]}, 32'h0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rst_mid_hready", {31'h0, in_hready[3]}, 32'h1);
    chk("rst_mid_htrans", {30'h0, out_htrans[3]}, 32'h0);
    chk("rst_mid_haddr", {1'b0, out_haddr[3]}, 32'h0);
    run("w10_rd", 3, 1'b0, 31'h80, 32'h0, 32'hCAFE_F00D, 1'b0, 12, ns, e1);

    // LFSR restarts from its seed after reset
    lm = 16'hACE1;
    for (int k = 0; k < 3; k++) begin
      nw = int'(lm[3:0]);
      lm = lfsr_next(lm);
      run("seed_rd", 2, 1'b0, 31'h200, 32'h0, mdl[0], 1'b0, nw + 2, ns, e1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ahb_wait_state_bridge.md
# ahb_wait_state_bridge

Single-outstanding AHB-Lite bridge that sits directly upstream of the 31-bit-address testbench RAM slave port. It sits between the core's AHB master and that port, and forwards every transfer unchanged in address, size, direction and data. Before each forwarded transfer it inserts a fixed or pseudo-random number of wait states, so the core's stall paths are stressed. Read data and error responses return to the core one cycle after the downstream data phase completes.

## Interface
- WAIT_CYCLES, 0, fixed wait states inserted per transfer when RANDOM_WAIT=0 (0..15)
- RANDOM_WAIT, 0, 1 = per-transfer wait count taken from an LFSR instead of WAIT_CYCLES
- LFSR_SEED, 16'hACE1, LFSR reset value; must be non-zero
- clock  in  1  sole clock; all state changes on rising edge
- reset  in  1  synchronous, active-high reset
- io_in_hready  out  1  upstream HREADY (transfer/data phase complete)
- io_in_htrans  in  2  upstream HTRANS
- io_in_hsize  in  3  upstream HSIZE
- io_in_hwrite  in  1  upstream HWRITE
- io_in_haddr  in  31  upstream HADDR
- io_in_hwdata  in  32  upstream HWDATA (data phase)
- io_in_hresp  out  1  upstream HRESP (1 = ERROR)
- io_in_hrdata  out  32  upstream HRDATA
- io_out_hready  in  1  downstream HREADY from RAM slave port
- io_out_htrans  out  2  downstream HTRANS
- io_out_hsize  out  3  downstream HSIZE
- io_out_hwrite  out  1  downstream HWRITE
- io_out_haddr  out  31  downstream HADDR
- io_out_hwdata  out  32  downstream HWDATA
- io_out_hresp  in  1  downstream HRESP
- io_out_hrdata  in  32  downstream HRDATA

## Operation
- FSM states: IDLE, WAIT, ADDR, DATA, ERR, RESP. The upstream side is ready (io_in_hready=1) only in IDLE and RESP.
- Accept: in IDLE or RESP, if io_in_htrans[1]=1 (NONSEQ or SEQ), register hsize, hwrite and haddr. BUSY (01) and IDLE (00) are not accepted.
- Wait count: when a transfer is accepted, wcnt loads WAIT_CYCLES or lfsr[3:0]. The next state is WAIT if wcnt≠0, otherwise ADDR.
- LFSR: 16-bit Fibonacci, fb = l[15]^l[13]^l[12]^l[10], l <= {l[14:0],fb}. It advances exactly once per accepted transfer, even when RANDOM_WAIT=0.
- io_in_hwdata is captured on the first cycle after acceptance and is held in a register.
- WAIT: wcnt decrements each cycle. When wcnt reaches 1, the next state is ADDR.
- ADDR:
  - io_out_htrans=2'b10 (SEQ is always issued as NONSEQ), with the registered control and address.
  - If io_out_hready=1, go to DATA. Otherwise hold ADDR with all outputs stable.
- DATA:
  - io_out_htrans=2'b00; io_out_hwdata=captured data.
  - When io_out_hready=1, latch io_out_hrdata and io_out_hresp, then go to ERR if hresp=1, else RESP.
  - io_out_hresp=1 while io_out_hready=0 is ignored; only the completing cycle counts.
- ERR: io_in_hready=0, io_in_hresp=1 (first cycle of the two-cycle error). Next state is RESP.
- RESP: io_in_hready=1, io_in_hresp=latched resp, io_in_hrdata=latched rdata (reads only; 0 for writes). A new transfer may be accepted in this same cycle; otherwise go to IDLE.
- IDLE: io_in_hready=1, io_in_hresp=0, io_in_hrdata=0; downstream htrans=0.
- The bridge holds at most one transfer at a time; downstream never sees back-to-back pipelined address phases.
- Reset values: io_in_hready=1; io_in_hresp=0; io_in_hrdata=0; all io_out_* outputs 0; state IDLE; lfsr=LFSR_SEED; wcnt=0.
- Reset mid-transfer abandons the transfer immediately. Downstream htrans is driven IDLE from the next cycle.

## Timing
- All outputs are registered or decoded from state only; there are no combinational paths from input to output.
- Let T be the acceptance cycle, N the wait count, and D the number of downstream data-phase stall cycles, with io_out_hready high during ADDR.
  - WAIT covers T+1..T+N.
  - ADDR is at T+N+1; DATA is at T+N+2..T+N+2+D.
  - RESP is at T+N+3+D, or ERR at T+N+3+D followed by RESP at T+N+4+D.
- Minimum upstream stall (N=0, D=0) is 2 cycles of io_in_hready=0.
- Control, address and write data stay stable on the downstream port for as long as io_out_hready is low.

## Test plan
- WAIT_CYCLES=0: write 32'hDEADBEEF to 31'h0000_0100, then read it back.
  - io_in_hready is low for exactly 2 cycles per transfer.
  - The read returns 32'hDEADBEEF with hresp=0.
- WAIT_CYCLES=5: a single read of 31'h0000_0040.
  - io_in_hready is low for 7 cycles.
  - Downstream NONSEQ appears at T+6.
- Back-to-back NONSEQ, with the second presented in the RESP cycle: it is accepted with no IDLE gap and both data values are correct.
- Downstream forced ERROR (hresp=1, hready 0 then 1):
  - Upstream sees hresp=1/hready=0 followed by hresp=1/hready=1.
  - The next transfer completes with OKAY.
- RANDOM_WAIT=1, LFSR_SEED=16'hACE1, 1000 random transfers:
  - The per-transfer stall sequence matches the reference LFSR model.
  - Memory contents match the scoreboard.
- Reset asserted during WAIT with N=10:
  - The next cycle shows io_in_hready=1 and io_out_htrans=0.
  - A subsequent read is correct.
